// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem predecode initiator.
// Holds the predecode bundles, the initiator FSM states and a stall helper.
package fpu_ss_pkg;

   typedef struct packed {
      logic [31:0] q_instr_data;
   } acc_prd_req_t;

   typedef struct packed {
      logic       p_accept;
      logic       p_writeback;
      logic       p_is_mem_op;
      logic [2:0] p_use_rs;
   } acc_prd_rsp_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREDEC = 2'd1,
      WAIT   = 2'd2,
      ISSUE  = 2'd3
   } prd_init_state_e;

   // Stall while any needed operand is missing or no writeback credit is left.
   function automatic logic prd_blocked(
      input acc_prd_rsp_t rsp,
      input logic [2:0]   rs_valid,
      input logic         wb_full
   );
      return (|(rsp.p_use_rs & ~rs_valid)) | (rsp.p_writeback & wb_full);
   endfunction

endpackage

// File: rtl/fpu_ss_wb_credit_cnt.sv
// Up/down counter of outstanding writeback instructions.
// Saturates at both ends; a decrement at zero sets a sticky underflow flag.
module fpu_ss_wb_credit_cnt #(
   parameter int unsigned MaxOutstandingWb = 4,
   localparam int unsigned CntWidth = $clog2(MaxOutstandingWb + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                inc_i,
   input  logic                dec_i,
   output logic                full_o,
   output logic [CntWidth-1:0] cnt_o,
   output logic                underflow_o
);

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstandingWb);

   logic [CntWidth-1:0] cnt_d, cnt_q;
   logic                uf_d, uf_q;

   always_comb begin
      cnt_d = cnt_q;
      uf_d  = uf_q;
      if (inc_i && !dec_i) begin
         if (cnt_q != MaxCnt) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) begin
            uf_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         uf_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         uf_q  <= uf_d;
      end
   end

   assign full_o      = (cnt_q == MaxCnt);
   assign cnt_o       = cnt_q;
   assign underflow_o = uf_q;

endmodule

// File: rtl/fpu_ss_prd_initiator.sv
// Core-side predecode initiator: predecode, operand/credit wait, offload.
// One instruction in flight; the writeback credit counter gates issue.
module fpu_ss_prd_initiator
   import fpu_ss_pkg::*;
#(
   parameter int unsigned MaxOutstandingWb = 4,
   localparam int unsigned CntWidth = $clog2(MaxOutstandingWb + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   input  logic [31:0]         instr_data_i,
   output acc_prd_req_t        prd_req_o,
   input  acc_prd_rsp_t        prd_rsp_i,
   input  logic [2:0]          rs_valid_i,
   output logic                off_valid_o,
   input  logic                off_ready_i,
   output logic [31:0]         off_instr_o,
   output logic                off_writeback_o,
   output logic                off_is_mem_o,
   output logic [2:0]          off_use_rs_o,
   output logic                illegal_o,
   input  logic                wb_done_i,
   output logic [CntWidth-1:0] wb_pending_o,
   output logic                wb_underflow_o
);

   prd_init_state_e state_d, state_q;
   logic [31:0]     instr_d, instr_q;
   acc_prd_rsp_t    rsp_d, rsp_q;
   acc_prd_rsp_t    chk_rsp;
   logic            blocked;
   logic            wb_full;
   logic            wb_inc;

   logic in_idle, in_predec, in_issue;

   assign in_idle   = (state_q == IDLE);
   assign in_predec = (state_q == PREDEC);
   assign in_issue  = (state_q == ISSUE);

   // PREDEC decides on the live response, WAIT on the captured one.
   assign chk_rsp = in_predec ? prd_rsp_i : rsp_q;
   assign blocked = prd_blocked(chk_rsp, rs_valid_i, wb_full);

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      rsp_d   = rsp_q;
      unique case (state_q)
         IDLE: begin
            if (instr_valid_i) begin
               instr_d = instr_data_i;
               state_d = PREDEC;
            end
         end
         PREDEC: begin
            rsp_d = prd_rsp_i;
            if (!prd_rsp_i.p_accept) begin
               state_d = IDLE;
            end else if (blocked) begin
               state_d = WAIT;
            end else begin
               state_d = ISSUE;
            end
         end
         WAIT: begin
            if (!blocked) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (off_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         instr_q <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         rsp_q   <= rsp_d;
      end
   end

   assign instr_ready_o          = in_idle;
   assign prd_req_o.q_instr_data = in_idle ? 32'd0 : instr_q;
   assign illegal_o              = in_predec & ~prd_rsp_i.p_accept;

   assign off_valid_o     = in_issue;
   assign off_instr_o     = in_issue ? instr_q : 32'd0;
   assign off_writeback_o = in_issue & rsp_q.p_writeback;
   assign off_is_mem_o    = in_issue & rsp_q.p_is_mem_op;
   assign off_use_rs_o    = in_issue ? rsp_q.p_use_rs : 3'b000;

   assign wb_inc = off_valid_o & off_ready_i & off_writeback_o;

   fpu_ss_wb_credit_cnt #(
      .MaxOutstandingWb(MaxOutstandingWb)
   ) u_wb_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (wb_inc),
      .dec_i      (wb_done_i),
      .full_o     (wb_full),
      .cnt_o      (wb_pending_o),
      .underflow_o(wb_underflow_o)
   );

endmodule

// File: tb/tb_fpu_ss_prd_initiator.sv
// Directed bench for fpu_ss_prd_initiator with a small predecoder model.
// Expected offloads are queued on acceptance and popped at issue.
module tb_fpu_ss_prd_initiator;
   import fpu_ss_pkg::*;

   localparam int unsigned MaxWb = 2;
   localparam int unsigned CW    = $clog2(MaxWb + 1);

   localparam logic [31:0] FADD  = 32'h002081D3;
   localparam logic [31:0] ILL   = 32'h00000000;
   localparam logic [31:0] FMVWX = 32'hF00280D3;
   localparam logic [31:0] FMVXW = 32'hE00082D3;
   localparam logic [31:0] FLW   = 32'h00012087;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instr_data;
   acc_prd_req_t  prd_req;
   acc_prd_rsp_t  prd_rsp;
   logic [2:0]    rs_valid;
   logic          off_valid;
   logic          off_ready;
   logic [31:0]   off_instr;
   logic          off_wb;
   logic          off_mem;
   logic [2:0]    off_rs;
   logic          illegal;
   logic          wb_done;
   logic [CW-1:0] wb_pending;
   logic          wb_uf;

   typedef struct packed {
      logic [31:0] instr;
      logic        wb;
      logic        mem;
      logic [2:0]  rs;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   function automatic acc_prd_rsp_t predec(input logic [31:0] i);
      acc_prd_rsp_t r;
      r = '0;
      case (i)
         FADD: r.p_accept = 1'b1;
         FMVWX: begin
            r.p_accept = 1'b1;
            r.p_use_rs = 3'b001;
         end
         FMVXW: begin
            r.p_accept    = 1'b1;
            r.p_writeback = 1'b1;
         end
         FLW: begin
            r.p_accept    = 1'b1;
            r.p_is_mem_op = 1'b1;
            r.p_use_rs    = 3'b001;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   assign prd_rsp = predec(prd_req.q_instr_data);

   fpu_ss_prd_initiator #(
      .MaxOutstandingWb(MaxWb)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_valid_i  (instr_valid),
      .instr_ready_o  (instr_ready),
      .instr_data_i   (instr_data),
      .prd_req_o      (prd_req),
      .prd_rsp_i      (prd_rsp),
      .rs_valid_i     (rs_valid),
      .off_valid_o    (off_valid),
      .off_ready_i    (off_ready),
      .off_instr_o    (off_instr),
      .off_writeback_o(off_wb),
      .off_is_mem_o   (off_mem),
      .off_use_rs_o   (off_rs),
      .illegal_o      (illegal),
      .wb_done_i      (wb_done),
      .wb_pending_o   (wb_pending),
      .wb_underflow_o (wb_uf)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i);
      int n;
      acc_prd_rsp_t r;
      exp_t e;
      n = 0;
      while (!instr_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_ready", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      instr_data  = i;
      tick();
      instr_valid = 1'b0;
      instr_data  = 32'd0;
      r = predec(i);
      if (r.p_accept) begin
         e.instr = i;
         e.wb    = r.p_writeback;
         e.mem   = r.p_is_mem_op;
         e.rs    = r.p_use_rs;
         sb.push_back(e);
      end
      chk("prd_req", prd_req.q_instr_data, i);
   endtask

   task automatic cmp_issue(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_instr"}, off_instr, e.instr);
         chk({tag, "_wb"}, {31'd0, off_wb}, {31'd0, e.wb});
         chk({tag, "_mem"}, {31'd0, off_mem}, {31'd0, e.mem});
         chk({tag, "_rs"}, {29'd0, off_rs}, {29'd0, e.rs});
      end
   endtask

   task automatic wait_issue(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!off_valid && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'd0, off_valid}, 32'd1);
      if (exp_lat >= 0) begin
         chk({tag, "_lat"}, n, exp_lat);
      end
      cmp_issue(tag);
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr_data  = 32'd0;
      rs_valid    = 3'b111;
      off_ready   = 1'b1;
      wb_done     = 1'b0;
      tick();
      tick();
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_valid", {31'd0, off_valid}, 32'd0);
      chk("rst_ill", {31'd0, illegal}, 32'd0);
      chk("rst_pend", {30'd0, wb_pending}, 32'd0);
      chk("rst_uf", {31'd0, wb_uf}, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_req", prd_req.q_instr_data, 32'd0);

      send(FADD);
      chk("fadd_predec_valid", {31'd0, off_valid}, 32'd0);
      chk("fadd_predec_ready", {31'd0, instr_ready}, 32'd0);
      wait_issue("fadd", 1);
      tick();
      chk("fadd_ready", {31'd0, instr_ready}, 32'd1);
      chk("fadd_pend", {30'd0, wb_pending}, 32'd0);
      chk("fadd_idle_instr", off_instr, 32'd0);

      send(ILL);
      chk("ill_pulse", {31'd0, illegal}, 32'd1);
      chk("ill_valid", {31'd0, off_valid}, 32'd0);
      tick();
      chk("ill_clear", {31'd0, illegal}, 32'd0);
      chk("ill_ready", {31'd0, instr_ready}, 32'd1);
      chk("ill_valid2", {31'd0, off_valid}, 32'd0);

      rs_valid = 3'b000;
      send(FMVWX);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("fmvwx_wait", {31'd0, off_valid}, 32'd0);
      end
      rs_valid = 3'b001;
      tick();
      chk("fmvwx_valid", {31'd0, off_valid}, 32'd1);
      cmp_issue("fmvwx");
      tick();
      rs_valid = 3'b111;

      for (int i = 0; i < 2; i++) begin
         send(FMVXW);
         wait_issue("fmvxw", 1);
         tick();
      end
      chk("wb_pend2", {30'd0, wb_pending}, 32'd2);
      send(FMVXW);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wb_stall", {31'd0, off_valid}, 32'd0);
      end
      chk("wb_stall_pend", {30'd0, wb_pending}, 32'd2);
      wb_done = 1'b1;
      tick();
      wb_done = 1'b0;
      chk("wb_dec_pend", {30'd0, wb_pending}, 32'd1);
      chk("wb_dec_valid", {31'd0, off_valid}, 32'd0);
      tick();
      chk("wb_third_valid", {31'd0, off_valid}, 32'd1);
      cmp_issue("wb_third");
      tick();
      chk("wb_pend_back", {30'd0, wb_pending}, 32'd2);

      wb_done = 1'b1;
      tick();
      wb_done = 1'b0;
      chk("sim_pre", {30'd0, wb_pending}, 32'd1);
      send(FMVXW);
      wait_issue("sim", 1);
      wb_done = 1'b1;
      tick();
      wb_done = 1'b0;
      chk("sim_pend", {30'd0, wb_pending}, 32'd1);
      wb_done = 1'b1;
      tick();
      chk("uf_pend0", {30'd0, wb_pending}, 32'd0);
      chk("uf_not_yet", {31'd0, wb_uf}, 32'd0);
      tick();
      wb_done = 1'b0;
      chk("uf_pend_stay", {30'd0, wb_pending}, 32'd0);
      chk("uf_set", {31'd0, wb_uf}, 32'd1);
      tick();
      chk("uf_sticky", {31'd0, wb_uf}, 32'd1);

      off_ready = 1'b0;
      send(FLW);
      wait_issue("flw", 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flw_hold_valid", {31'd0, off_valid}, 32'd1);
         chk("flw_hold_instr", off_instr, FLW);
         chk("flw_hold_mem", {31'd0, off_mem}, 32'd1);
         chk("flw_hold_rs", {29'd0, off_rs}, 32'd1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      off_ready = 1'b1;
      chk("mid_rst_valid", {31'd0, off_valid}, 32'd0);
      chk("mid_rst_pend", {30'd0, wb_pending}, 32'd0);
      chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("mid_rst_uf", {31'd0, wb_uf}, 32'd0);
      chk("mid_rst_req", prd_req.q_instr_data, 32'd0);

      send(FADD);
      wait_issue("post_rst", 1);
      tick();
      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
